// File: rtl/txn_mapper_q.sv
`default_nettype none
// ============================================================================
// Module : txn_mapper_q
// Brief  : RNIC request address mapper with in-order pending queue and issue
//          gating by overflow stopper and per-bank busy flags.
// Rev    : 1.0
// ============================================================================
module txn_mapper_q #(
  parameter int DATA_W   = 32,
  parameter int BG_W     = 2,
  parameter int BA_W     = 2,
  parameter int ROW_W    = 16,
  parameter int COL_HI_W = 6,
  parameter int COL_LO_W = 4,
  parameter int IDX_W    = 6,
  parameter int PQ_DEPTH = 4,
  parameter int XOR_EN   = 1,
  parameter int PERM_T   = 5,
  parameter int ADDR_W   = ROW_W + BA_W + COL_HI_W + BG_W + COL_LO_W,
  parameter int NB       = 2 ** (BG_W + BA_W),
  parameter int CNT_W    = $clog2(PQ_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              in_type_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [ADDR_W-1:0] in_addr_i,
  input  logic              stop_read_i,
  input  logic              stop_write_i,
  input  logic [NB-1:0]     bank_busy_i,
  output logic              out_valid_o,
  output logic              out_type_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic [IDX_W-1:0]  out_index_o,
  output logic [NB-1:0]     bank_valid_o,
  output logic [CNT_W-1:0]  pq_count_o
);

  localparam int PTR_W   = $clog2(PQ_DEPTH);
  localparam int BK_W    = BG_W + BA_W;
  localparam int OFF_BG  = COL_LO_W;
  localparam int OFF_CH  = OFF_BG + BG_W;
  localparam int OFF_BA  = OFF_CH + COL_HI_W;
  localparam int OFF_ROW = OFF_BA + BA_W;

  logic [ROW_W-1:0]    row_w;
  logic [COL_HI_W-1:0] colhi_w;
  logic [COL_LO_W-1:0] collo_w;
  logic [BG_W-1:0]     bg_raw_w, bg_w;
  logic [BA_W-1:0]     ba_raw_w, ba_w;
  logic [ADDR_W-1:0]   map_addr_w;

  assign row_w    = in_addr_i[OFF_ROW +: ROW_W];
  assign ba_raw_w = in_addr_i[OFF_BA +: BA_W];
  assign colhi_w  = in_addr_i[OFF_CH +: COL_HI_W];
  assign bg_raw_w = in_addr_i[OFF_BG +: BG_W];
  assign collo_w  = in_addr_i[0 +: COL_LO_W];

  generate
    if (XOR_EN != 0) begin : g_xor
      assign ba_w = ba_raw_w ^ row_w[PERM_T +: BA_W];
      assign bg_w = bg_raw_w ^ row_w[PERM_T + BA_W +: BG_W];
    end else begin : g_noxor
      assign ba_w = ba_raw_w;
      assign bg_w = bg_raw_w;
    end
  endgenerate

  assign map_addr_w = {bg_w, ba_w, row_w, colhi_w, collo_w};

  // Pending-queue storage; occupancy is fully described by the pointers/count.
  logic              pq_type_q [PQ_DEPTH];
  logic [DATA_W-1:0] pq_data_q [PQ_DEPTH];
  logic [ADDR_W-1:0] pq_addr_q [PQ_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d, wr_idx_q, wr_idx_d;

  logic              push_w, issue_w, head_type_w;
  logic [DATA_W-1:0] head_data_w;
  logic [ADDR_W-1:0] head_addr_w;
  logic [BK_W-1:0]   head_bank_w;

  assign in_ready_o  = !rst && (count_q != CNT_W'(PQ_DEPTH));
  assign push_w      = in_valid_i && in_ready_o;
  assign head_type_w = pq_type_q[rd_ptr_q];
  assign head_data_w = pq_data_q[rd_ptr_q];
  assign head_addr_w = pq_addr_q[rd_ptr_q];
  assign head_bank_w = head_addr_w[ADDR_W-1 -: BK_W];
  assign issue_w     = (count_q != '0)
                     && !(head_type_w ? stop_write_i : stop_read_i)
                     && !bank_busy_i[head_bank_w];

  always_ff @(posedge clk) begin
    if (push_w) begin
      pq_type_q[wr_ptr_q] <= in_type_i;
      pq_data_q[wr_ptr_q] <= in_type_i ? in_data_i : '0;
      pq_addr_q[wr_ptr_q] <= map_addr_w;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push_w);
    rd_ptr_d = rd_ptr_q + PTR_W'(issue_w);
    count_d  = count_q + CNT_W'(push_w) - CNT_W'(issue_w);
    rd_idx_d = rd_idx_q + IDX_W'(issue_w && !head_type_w);
    wr_idx_d = wr_idx_q + IDX_W'(issue_w && head_type_w);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rd_idx_q     <= '0;
      wr_idx_q     <= '0;
      out_valid_o  <= 1'b0;
      bank_valid_o <= '0;
      out_type_o   <= 1'b0;
      out_data_o   <= '0;
      out_addr_o   <= '0;
      out_index_o  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rd_idx_q     <= rd_idx_d;
      wr_idx_q     <= wr_idx_d;
      out_valid_o  <= issue_w;
      bank_valid_o <= issue_w ? (NB'(1) << head_bank_w) : '0;
      // Payload outputs hold their last issued values while idle.
      if (issue_w) begin
        out_type_o  <= head_type_w;
        out_data_o  <= head_data_w;
        out_addr_o  <= head_addr_w;
        out_index_o <= head_type_w ? wr_idx_q : rd_idx_q;
      end
    end
  end

  assign pq_count_o = count_q;

endmodule
`default_nettype wire
